// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide memory controller: access size codes,
// FSM state encodings and the size-to-byte-count helper.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Size code 3 is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte lane for the memory controller: picks the store byte for the current
// count and merges returning load bytes into a 32-bit assembly register.
module mem_byte_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_capture,
    input  logic [1:0]  i_cap_idx,
    input  logic [7:0]  i_din,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_wr_idx,
    output logic [7:0]  o_wbyte,
    output logic [31:0] o_asm
);

    logic [31:0] r_asm;

    // Cleared on accept so bytes at or above the access size read back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm <= 32'd0;
        end else if (i_clear) begin
            r_asm <= 32'd0;
        end else if (i_capture) begin
            r_asm[{i_cap_idx, 3'b000} +: 8] <= i_din;
        end
    end

    assign o_wbyte = i_wdata[{i_wr_idx, 3'b000} +: 8];
    assign o_asm   = r_asm;

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// MEM stage, sequencing 1/2/4-byte MEM accesses little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_addr_i,
    output logic [7:0]  if_byte_o,
    output logic        if_stall_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_busy_o,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i,
    output logic [1:0]  dbg_state_o
);

    state_t      r_state;
    logic [2:0]  r_count;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;

    logic        w_accept;
    logic        w_capture;
    logic        w_mem_owns;
    logic [2:0]  w_nbytes;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_addr;
    logic [7:0]  w_wbyte;
    logic [31:0] w_asm;

    assign w_nbytes   = size_bytes(r_size);
    assign w_accept   = (r_state == ST_IDLE) && mem_req_i;
    assign w_capture  = (r_state == ST_RD) && (r_count != 3'd0);
    assign w_cap_idx  = r_count[1:0] - 2'd1;
    assign w_addr     = r_base + {29'd0, r_count};
    assign w_mem_owns = (r_state == ST_RD) || (r_state == ST_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        r_count <= 3'd0;
                        r_state <= mem_we_i ? ST_WR : ST_RD;
                    end
                end
                // A load runs one extra count so the last byte can land.
                ST_RD: begin
                    if (r_count == w_nbytes) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= r_count + 3'd1;
                    end
                end
                ST_WR: begin
                    if (r_count == w_nbytes - 3'd1) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= r_count + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_base  <= mem_addr_i;
            r_size  <= mem_size_i;
            r_wdata <= mem_wdata_i;
        end
    end

    mem_byte_lane u_lane (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_capture (w_capture),
        .i_cap_idx (w_cap_idx),
        .i_din     (ram_din_i),
        .i_wdata   (r_wdata),
        .i_wr_idx  (r_count[1:0]),
        .o_wbyte   (w_wbyte),
        .o_asm     (w_asm)
    );

    // The write strobe is gated by reset so an interrupted store stops at once.
    assign ram_addr_o  = w_mem_owns ? w_addr : if_addr_i;
    assign ram_wr_o    = (r_state == ST_WR) && !rst;
    assign ram_dout_o  = w_wbyte;
    assign if_byte_o   = ram_din_i;
    assign if_stall_o  = mem_req_i || (r_state != ST_IDLE);
    assign mem_busy_o  = (r_state != ST_IDLE);
    assign mem_done_o  = (r_state == ST_DONE);
    assign mem_rdata_o = w_asm;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model with 1-cycle read latency,
// table of MEM accesses plus fetch, back-to-back and reset-during-store sequences.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] if_addr_i;
    logic [7:0]  if_byte_o;
    logic        if_stall_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_busy_o;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
    logic [1:0]  dbg_state_o;

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .if_addr_i   (if_addr_i),
        .if_byte_o   (if_byte_o),
        .if_stall_o  (if_stall_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_size_i  (mem_size_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_busy_o  (mem_busy_o),
        .mem_done_o  (mem_done_o),
        .mem_rdata_o (mem_rdata_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wr_o    (ram_wr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // RAM model: 64 KiB window on addr[15:0], registered read data
    logic [7:0] ram_mem [0:65535];

    always @(posedge clk) begin
        ram_din_i <= ram_mem[ram_addr_o[15:0]];
        if (ram_wr_o) ram_mem[ram_addr_o[15:0]] <= ram_dout_o;
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: one full MEM access from accept through the cycle after DONE
    task automatic run_access(input string name, input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input int nb, input int lat);
        logic [31:0] a;
        logic [31:0] exp_v;
        logic [7:0]  b;
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_size_i  = size;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        if_addr_i   = $urandom;
        if (!we) exp_q.push_back(exp_rdata);
        #2;
        check({name, " stall@A"}, 32'(if_stall_o), 32'd1);
        check({name, " addr@A"}, ram_addr_o, if_addr_i);
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            step();
            mem_addr_i  = $urandom;
            mem_wdata_i = $urandom;
            mem_size_i  = 2'($urandom_range(0, 3));
            mem_we_i    = 1'($urandom_range(0, 1));
            if_addr_i   = $urandom;
            if (cyc == lat + 1) mem_req_i = 1'b0;
            #2;
            check($sformatf("%s stall@A+%0d", name, cyc), 32'(if_stall_o), 32'(cyc <= lat));
            check($sformatf("%s busy@A+%0d", name, cyc), 32'(mem_busy_o), 32'(cyc <= lat));
            check($sformatf("%s done@A+%0d", name, cyc), 32'(mem_done_o), 32'(cyc == lat));
            check($sformatf("%s wr@A+%0d", name, cyc), 32'(ram_wr_o), 32'(we && cyc <= nb));
            if (cyc <= nb) begin
                a = addr + 32'(cyc - 1);
                check($sformatf("%s ram_addr@A+%0d", name, cyc), ram_addr_o, a);
                if (we) begin
                    b = wdata[8*(cyc-1) +: 8];
                    check($sformatf("%s dout@A+%0d", name, cyc), 32'(ram_dout_o), 32'(b));
                end
            end
            if (cyc == lat && !we && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check({name, " rdata"}, mem_rdata_o, exp_v);
            end
            if (cyc == lat + 1) begin
                check({name, " idle after done"}, 32'(dbg_state_o), 32'(ST_IDLE));
                check({name, " fetch owns bus"}, ram_addr_o, if_addr_i);
                if (!we) check({name, " rdata held"}, mem_rdata_o, exp_rdata);
            end
        end
        step();
        if (we) begin
            for (int k = 0; k < nb; k++) begin
                a = addr + 32'(k);
                b = wdata[8*k +: 8];
                check($sformatf("%s ram[%08h]", name, a), 32'(ram_mem[a[15:0]]), 32'(b));
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          nb;
        int          lat;
    } vec_t;

    vec_t vecs[9];
    logic [7:0] got_b;

    initial begin
        // vectors: we, size, addr, wdata, expected rdata, bytes, done latency
        vecs[0] = '{1'b0, SIZE_W, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 4, 6};
        vecs[1] = '{1'b1, SIZE_H, 32'h0000_2001, 32'h0000_BEEF,  32'h0,         2, 3};
        vecs[2] = '{1'b0, SIZE_B, 32'hFFFF_FFFF, 32'h0,          32'h0000_005A, 1, 3};
        vecs[3] = '{1'b0, SIZE_W, 32'hFFFF_FFFE, 32'h0,          32'h3322_5A11, 4, 6};
        vecs[4] = '{1'b0, SIZE_H, 32'h0000_2001, 32'h0,          32'h0000_BEEF, 2, 4};
        vecs[5] = '{1'b1, 2'd3,   32'h0000_3000, 32'hCAFE_F00D,  32'h0,         4, 5};
        vecs[6] = '{1'b0, 2'd3,   32'h0000_3000, 32'h0,          32'hCAFE_F00D, 4, 6};
        vecs[7] = '{1'b1, SIZE_B, 32'h0000_4000, 32'h1234_56A5,  32'h0,         1, 2};
        vecs[8] = '{1'b0, SIZE_B, 32'h0000_4000, 32'h0,          32'h0000_00A5, 1, 3};

        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
        ram_mem[16'h0100] = 8'h13;
        ram_mem[16'h0101] = 8'h00;
        ram_mem[16'h1000] = 8'hEF;
        ram_mem[16'h1001] = 8'hBE;
        ram_mem[16'h1002] = 8'hAD;
        ram_mem[16'h1003] = 8'hDE;
        ram_mem[16'h2003] = 8'h77;
        ram_mem[16'h4001] = 8'h66;
        ram_mem[16'hFFFE] = 8'h11;
        ram_mem[16'hFFFF] = 8'h5A;
        ram_mem[16'h0000] = 8'h22;
        ram_mem[16'h0001] = 8'h33;
        for (int i = 0; i < 4; i++) ram_mem[16'h5000 + i] = 8'hAA;

        rst         = 1'b1;
        if_addr_i   = 32'h0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_size_i  = 2'd0;
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h0;
        ram_din_i   = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        #2;
        check("reset state", 32'(dbg_state_o), 32'(ST_IDLE));
        check("reset done", 32'(mem_done_o), 32'd0);
        check("reset rdata", mem_rdata_o, 32'd0);
        check("reset wr", 32'(ram_wr_o), 32'd0);
        check("reset stall", 32'(if_stall_o), 32'd0);
        check("reset busy", 32'(mem_busy_o), 32'd0);
        step();

        // idle fetch: byte appears one cycle after its address
        if_addr_i = 32'h0000_0100;
        exp_q.push_back(32'h13);
        #2;
        check("fetch stall c0", 32'(if_stall_o), 32'd0);
        check("fetch addr c0", ram_addr_o, 32'h0000_0100);
        step();
        if_addr_i = 32'h0000_0101;
        exp_q.push_back(32'h00);
        #2;
        check("fetch byte 0x100", 32'(if_byte_o), exp_q.pop_front());
        check("fetch stall c1", 32'(if_stall_o), 32'd0);
        step();
        if_addr_i = 32'h0000_0102;
        #2;
        check("fetch byte 0x101", 32'(if_byte_o), exp_q.pop_front());
        check("fetch stall c2", 32'(if_stall_o), 32'd0);
        step();

        // table: accesses issued back to back, one request-low cycle apart
        for (int i = 0; i < 9; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr,
                       vecs[i].wdata, vecs[i].exp_rdata, vecs[i].nb, vecs[i].lat);
        end
        check("half store left 0x2003", 32'(ram_mem[16'h2003]), 32'h77);
        check("byte store left 0x4001", 32'(ram_mem[16'h4001]), 32'h66);

        // reset during a word store after two bytes
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_size_i  = SIZE_W;
        mem_addr_i  = 32'h0000_5000;
        mem_wdata_i = 32'h1122_3344;
        #2;
        check("rstwr accept stall", 32'(if_stall_o), 32'd1);
        step();
        #2;
        check("rstwr wr0", 32'(ram_wr_o), 32'd1);
        check("rstwr dout0", 32'(ram_dout_o), 32'h44);
        step();
        #2;
        check("rstwr addr1", ram_addr_o, 32'h0000_5001);
        check("rstwr dout1", 32'(ram_dout_o), 32'h33);
        step();
        rst = 1'b1;
        #2;
        check("rstwr wr during rst", 32'(ram_wr_o), 32'd0);
        step();
        rst       = 1'b0;
        mem_req_i = 1'b0;
        #2;
        check("rstwr state", 32'(dbg_state_o), 32'(ST_IDLE));
        check("rstwr wr after", 32'(ram_wr_o), 32'd0);
        check("rstwr rdata", mem_rdata_o, 32'd0);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("rstwr no done c%0d", c), 32'(mem_done_o), 32'd0);
            step();
            #2;
        end
        got_b = ram_mem[16'h5000];
        check("rstwr ram 0x5000", 32'(got_b), 32'h44);
        got_b = ram_mem[16'h5001];
        check("rstwr ram 0x5001", 32'(got_b), 32'h33);
        got_b = ram_mem[16'h5002];
        check("rstwr ram 0x5002", 32'(got_b), 32'hAA);
        got_b = ram_mem[16'h5003];
        check("rstwr ram 0x5003", 32'(got_b), 32'hAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
